// File: rtl/hdmi_capture_ctrl.sv
// hdmi_capture_ctrl: sequences capture of the packed 2-pixel HDMI RX stream into the framebuffer write port.
//
// Measures the incoming frame geometry (pairs per line, lines per frame), locks once two
// consecutive frames measure identical and nonzero, then on arm_i captures one frame (or every
// frame while continuous_i is high) starting at a vsync rising edge. Pairs are written linearly
// from base_addr_i through a single output register with a valid/ready handshake.
//
// Ports:
//   clk_i, rst_i        pixel clock, synchronous active-high reset
//   link_up_i, enable_i must both be high to leave IDLE; dropping either returns to IDLE
//   vsync_i, de_i       RX timing; frame starts at vsync rising edge
//   pixel_i, pixel_valid_i  packed pixel pair {first, second} and its qualifier
//   arm_i               1-cycle capture request (also clears overflow_o)
//   continuous_i        re-arm automatically after each captured frame
//   base_addr_i         start pair address, sampled at frame start
//   wr_addr_o, wr_data_o, wr_valid_o, wr_ready_i  framebuffer write port
//   h_pairs_o, v_lines_o, locked_o  locked geometry
//   busy_o              waiting for vsync or capturing
//   done_o              1-cycle pulse per fully captured frame
//   overflow_o          sticky write overflow flag
//   frames_o, drops_o   only with HDMI_CAPTURE_STATS_EN defined: done and abort counters
module hdmi_capture_ctrl #(
    parameter int HCNT_W = 11,
    parameter int VCNT_W = 11,
    parameter int ADDR_W = 20
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              link_up_i,
    input  logic              vsync_i,
    input  logic              de_i,
    input  logic [47:0]       pixel_i,
    input  logic              pixel_valid_i,
    input  logic              enable_i,
    input  logic              arm_i,
    input  logic              continuous_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [47:0]       wr_data_o,
    output logic              wr_valid_o,
    input  logic              wr_ready_i,
    output logic [HCNT_W-1:0] h_pairs_o,
    output logic [VCNT_W-1:0] v_lines_o,
    output logic              locked_o,
`ifdef HDMI_CAPTURE_STATS_EN
    output logic [15:0]       frames_o,
    output logic [15:0]       drops_o,
`endif
    output logic              busy_o,
    output logic              done_o,
    output logic              overflow_o
);
    localparam int PCNT_W = HCNT_W + VCNT_W;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SYNC    = 3'd1;
    localparam logic [2:0] S_MEASURE = 3'd2;
    localparam logic [2:0] S_READY   = 3'd3;
    localparam logic [2:0] S_WAIT_VS = 3'd4;
    localparam logic [2:0] S_CAPTURE = 3'd5;

    logic [2:0]        state_q, state_d;
    logic              vsync_q, de_q;
    logic [HCNT_W-1:0] h_cnt_q, h_cnt_d, prev_h_q, prev_h_d, h_pairs_q, h_pairs_d, h_base;
    logic [VCNT_W-1:0] v_cnt_q, v_cnt_d, prev_v_q, prev_v_d, v_lines_q, v_lines_d, v_base;
    logic              locked_q, locked_d;
    logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic [47:0]       wr_data_q, wr_data_d;
    logic              wr_valid_q, wr_valid_d, done_q, done_d, overflow_q, overflow_d;
    logic [PCNT_W-1:0] pair_cnt_q, pair_cnt_d, total;

    logic vs_rise, de_rise, pix, link_ok, meas_ok, meas_same, geom_same, last;

    assign vs_rise   = vsync_i & ~vsync_q;
    assign de_rise   = de_i & ~de_q;
    assign pix       = de_i & pixel_valid_i;
    assign link_ok   = enable_i & link_up_i;
    // The measurement taken at vs_rise is the counter value before this cycle's clear.
    assign meas_ok   = (h_cnt_q != '0) && (v_cnt_q != '0) && (h_cnt_q != '1) && (v_cnt_q != '1);
    assign meas_same = (h_cnt_q == prev_h_q) && (v_cnt_q == prev_v_q);
    assign geom_same = (h_cnt_q == h_pairs_q) && (v_cnt_q == v_lines_q);
    assign total     = PCNT_W'(h_pairs_q) * PCNT_W'(v_lines_q);
    assign last      = pair_cnt_q == total;

    // h restarts on each DE run and at frame start; both counters saturate at all-ones.
    assign h_base  = (vs_rise || de_rise) ? '0 : h_cnt_q;
    assign h_cnt_d = h_base + HCNT_W'(pix && (h_base != '1));
    assign v_base  = vs_rise ? '0 : v_cnt_q;
    assign v_cnt_d = v_base + VCNT_W'(de_rise && (v_base != '1));

    always_comb begin
        state_d    = state_q;
        prev_h_d   = prev_h_q;
        prev_v_d   = prev_v_q;
        h_pairs_d  = h_pairs_q;
        v_lines_d  = v_lines_q;
        locked_d   = locked_q;
        addr_d     = addr_q;
        pair_cnt_d = pair_cnt_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_valid_d = wr_valid_q & ~wr_ready_i;
        done_d     = 1'b0;
        overflow_d = overflow_q & ~arm_i;
        if (!link_ok) begin
            state_d    = S_IDLE;
            locked_d   = 1'b0;
            wr_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_SYNC;
                S_SYNC: begin
                    if (vs_rise) begin
                        state_d  = S_MEASURE;
                        prev_h_d = '0;
                        prev_v_d = '0;
                    end
                end
                S_MEASURE: begin
                    if (vs_rise && meas_ok && meas_same) begin
                        state_d   = S_READY;
                        locked_d  = 1'b1;
                        h_pairs_d = h_cnt_q;
                        v_lines_d = v_cnt_q;
                    end else if (vs_rise) begin
                        prev_h_d = h_cnt_q;
                        prev_v_d = v_cnt_q;
                    end
                end
                S_READY: begin
                    if (arm_i) begin
                        state_d = S_WAIT_VS;
                    end else if (vs_rise && !geom_same) begin
                        state_d  = S_MEASURE;
                        locked_d = 1'b0;
                        prev_h_d = h_cnt_q;
                        prev_v_d = v_cnt_q;
                    end
                end
                S_WAIT_VS: begin
                    if (vs_rise) begin
                        state_d    = S_CAPTURE;
                        addr_d     = base_addr_i;
                        pair_cnt_d = '0;
                    end
                end
                S_CAPTURE: begin
                    if (wr_valid_q && wr_ready_i && last) begin
                        done_d  = 1'b1;
                        state_d = continuous_i ? S_WAIT_VS : S_READY;
                    end else if (vs_rise) begin
                        // Frame ended before the expected pair count: geometry is no longer trusted.
                        state_d    = S_MEASURE;
                        locked_d   = 1'b0;
                        wr_valid_d = 1'b0;
                        prev_h_d   = h_cnt_q;
                        prev_v_d   = v_cnt_q;
                    end else if (pix && !last) begin
                        if (wr_valid_q && !wr_ready_i) begin
                            overflow_d = 1'b1;
                            wr_valid_d = 1'b0;
                            state_d    = continuous_i ? S_WAIT_VS : S_READY;
                        end else begin
                            wr_valid_d = 1'b1;
                            wr_addr_d  = addr_q;
                            wr_data_d  = pixel_i;
                            addr_d     = addr_q + 1'b1;
                            pair_cnt_d = pair_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            vsync_q    <= 1'b0;
            de_q       <= 1'b0;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            prev_h_q   <= '0;
            prev_v_q   <= '0;
            h_pairs_q  <= '0;
            v_lines_q  <= '0;
            locked_q   <= 1'b0;
            addr_q     <= '0;
            pair_cnt_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_valid_q <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            vsync_q    <= vsync_i;
            de_q       <= de_i;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            prev_h_q   <= prev_h_d;
            prev_v_q   <= prev_v_d;
            h_pairs_q  <= h_pairs_d;
            v_lines_q  <= v_lines_d;
            locked_q   <= locked_d;
            addr_q     <= addr_d;
            pair_cnt_q <= pair_cnt_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_valid_q <= wr_valid_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef HDMI_CAPTURE_STATS_EN
    logic [15:0] frames_q, frames_d, drops_q, drops_d;
    logic        abort;
    // Any exit from CAPTURE other than completion is an aborted capture.
    assign abort    = (state_q == S_CAPTURE) && (state_d != S_CAPTURE) && !done_d;
    assign frames_d = frames_q + 16'(done_d);
    assign drops_d  = drops_q + 16'(abort);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frames_q <= '0;
            drops_q  <= '0;
        end else begin
            frames_q <= frames_d;
            drops_q  <= drops_d;
        end
    end
    assign frames_o = frames_q;
    assign drops_o  = drops_q;
`endif

    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;
    assign wr_valid_o = wr_valid_q;
    assign h_pairs_o  = h_pairs_q;
    assign v_lines_o  = v_lines_q;
    assign locked_o   = locked_q;
    assign busy_o     = (state_q == S_WAIT_VS) || (state_q == S_CAPTURE);
    assign done_o     = done_q;
    assign overflow_o = overflow_q;
endmodule

// File: tb/tb_hdmi_capture_ctrl.sv
// tb_hdmi_capture_ctrl: directed table-driven bench for hdmi_capture_ctrl.
module tb_hdmi_capture_ctrl;
    logic        clk = 1'b0;
    logic        rst, link_up, vsync, de, pixel_valid, enable, arm, continuous, wr_ready;
    logic [47:0] pixel;
    logic [19:0] base_addr, wr_addr;
    logic [47:0] wr_data;
    logic        wr_valid, locked, busy, done, overflow;
    logic [10:0] h_pairs, v_lines;
`ifdef HDMI_CAPTURE_STATS_EN
    logic [15:0] frames, drops;
`endif

    always #5 clk = ~clk;

    hdmi_capture_ctrl dut (
        .clk_i(clk), .rst_i(rst), .link_up_i(link_up), .vsync_i(vsync), .de_i(de),
        .pixel_i(pixel), .pixel_valid_i(pixel_valid), .enable_i(enable), .arm_i(arm),
        .continuous_i(continuous), .base_addr_i(base_addr), .wr_addr_o(wr_addr),
        .wr_data_o(wr_data), .wr_valid_o(wr_valid), .wr_ready_i(wr_ready),
        .h_pairs_o(h_pairs), .v_lines_o(v_lines), .locked_o(locked),
`ifdef HDMI_CAPTURE_STATS_EN
        .frames_o(frames), .drops_o(drops),
`endif
        .busy_o(busy), .done_o(done), .overflow_o(overflow)
    );

    typedef struct {
        bit          arm;
        int          h;
        int          v;
        logic [19:0] base;
        bit          cont;
        int          nfr;
        int          stall_at;
        int          link_at;
        int          wpf;
        int          ndone;
        bit          ovf;
        bit          locked;
        bit          busy;
    } vec_t;

    vec_t        tbl[6];
    int          checks = 0, failures = 0;
    logic [19:0] wa[1024];
    logic [47:0] wd[1024];
    int          wr_n = 0, done_n = 0;
    logic        lnk_valid, lnk_locked;

    // Handshakes and done pulses sampled mid-cycle, inputs are stable by then.
    always @(negedge clk) begin
        if (wr_valid && wr_ready && wr_n < 1024) begin
            wa[wr_n] = wr_addr;
            wd[wr_n] = wr_data;
            wr_n++;
        end
        if (done) done_n++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] pix_of(int tag, int l, int p);
        return {16'hC0DE, 8'(tag), 8'(l), 8'(p), 8'(~p)};
    endfunction

    task automatic idle(int n);
        de = 0; pixel_valid = 0; wr_ready = 1;
        repeat (n) tick();
    endtask

    task automatic send_frame(int h, int v, int tag, int stall_at, int link_at);
        idle(2);
        vsync = 1; idle(2);
        vsync = 0; idle(2);
        for (int l = 0; l < v; l++) begin
            for (int p = 0; p < h; p++) begin
                int k;
                k = l * h + p;
                de = 1; pixel_valid = 1;
                pixel = pix_of(tag, l, p);
                wr_ready = !(stall_at >= 0 && k >= stall_at && k <= stall_at + 1);
                if (k == link_at) link_up = 0;
                tick();
                if (k == link_at) begin
                    lnk_valid  = wr_valid;
                    lnk_locked = locked;
                end
            end
            idle(3);
        end
    endtask

    task automatic check_writes(string nm, int w0, int n_exp, int wpf, int h, logic [19:0] base);
        int n;
        n = wr_n - w0;
        chk({nm, "_nwrites"}, 64'(n), 64'(n_exp));
        for (int i = 0; i < n && i < n_exp; i++) begin
            int f, k;
            logic [19:0] ea;
            f  = i / wpf;
            k  = i % wpf;
            ea = base + 20'(k);
            chk({nm, "_addr"}, 64'(wa[w0 + i]), 64'(ea));
            chk({nm, "_data"}, 64'(wd[w0 + i]), 64'(pix_of(f, k / h, k % h)));
        end
    endtask

    initial begin
        int w0, d0;
        tbl[0] = '{1, 8, 4, 20'h00100, 0, 1, -1, -1, 32, 1, 0, 1, 0};
        tbl[1] = '{1, 8, 4, 20'hFFFF0, 1, 3, -1, -1, 32, 3, 0, 1, 1};
        tbl[2] = '{0, 8, 4, 20'h00200, 0, 1, -1, -1, 32, 1, 0, 1, 0};
        tbl[3] = '{1, 8, 4, 20'h00300, 0, 1, 10, -1,  9, 0, 1, 1, 0};
        tbl[4] = '{1, 8, 4, 20'h00400, 0, 1, -1, -1, 32, 1, 0, 1, 0};
        tbl[5] = '{1, 8, 4, 20'h00500, 0, 1, -1, 10, 10, 0, 0, 0, 0};

        rst = 1; link_up = 0; vsync = 0; de = 0; pixel_valid = 0; pixel = '0;
        enable = 0; arm = 0; continuous = 0; wr_ready = 1; base_addr = '0;
        lnk_valid = 1; lnk_locked = 1;
        repeat (3) tick();
        chk("rst_wr_valid", 64'(wr_valid), 0);
        chk("rst_locked", 64'(locked), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_overflow", 64'(overflow), 0);
        chk("rst_h_pairs", 64'(h_pairs), 0);
        chk("rst_v_lines", 64'(v_lines), 0);
        rst = 0;
        enable = 1; link_up = 1;
        idle(2);

        send_frame(8, 4, 0, -1, -1);
        send_frame(8, 4, 0, -1, -1);
        chk("lock_not_early", 64'(locked), 0);
        send_frame(8, 4, 0, -1, -1);
        chk("lock_locked", 64'(locked), 1);
        chk("lock_h", 64'(h_pairs), 8);
        chk("lock_v", 64'(v_lines), 4);

        for (int e = 0; e < 6; e++) begin
            w0 = wr_n; d0 = done_n;
            base_addr = tbl[e].base;
            continuous = tbl[e].cont;
            if (tbl[e].arm) begin
                arm = 1; tick(); arm = 0;
                chk($sformatf("v%0d_arm_clears_ovf", e), 64'(overflow), 0);
                chk($sformatf("v%0d_arm_busy", e), 64'(busy), 1);
            end
            for (int f = 0; f < tbl[e].nfr; f++) send_frame(tbl[e].h, tbl[e].v, f, tbl[e].stall_at, tbl[e].link_at);
            idle(2);
            check_writes($sformatf("v%0d", e), w0, tbl[e].nfr * tbl[e].wpf, tbl[e].wpf, tbl[e].h, tbl[e].base);
            chk($sformatf("v%0d_done", e), 64'(done_n - d0), 64'(tbl[e].ndone));
            chk($sformatf("v%0d_ovf", e), 64'(overflow), 64'(tbl[e].ovf));
            chk($sformatf("v%0d_locked", e), 64'(locked), 64'(tbl[e].locked));
            chk($sformatf("v%0d_busy", e), 64'(busy), 64'(tbl[e].busy));
`ifdef HDMI_CAPTURE_STATS_EN
            if (e == 3) chk("v3_drops", 64'(drops), 1);
`endif
        end

        chk("link_next_valid", 64'(lnk_valid), 0);
        chk("link_next_locked", 64'(lnk_locked), 0);
        link_up = 1;
        for (int f = 0; f < 3; f++) send_frame(8, 4, 0, -1, -1);
        chk("relink_locked", 64'(locked), 1);
        chk("relink_h", 64'(h_pairs), 8);

        send_frame(6, 4, 0, -1, -1);
        send_frame(6, 4, 0, -1, -1);
        chk("geom_change_unlock", 64'(locked), 0);
        send_frame(6, 4, 0, -1, -1);
        chk("geom_relock", 64'(locked), 1);
        chk("geom_h", 64'(h_pairs), 6);
        chk("geom_v", 64'(v_lines), 4);

        w0 = wr_n; d0 = done_n;
        base_addr = 20'h00600;
        arm = 1; tick(); arm = 0;
        send_frame(6, 2, 0, -1, -1);
        check_writes("short", w0, 12, 12, 6, 20'h00600);
        send_frame(6, 4, 0, -1, -1);
        idle(2);
        chk("short_done", 64'(done_n - d0), 0);
        chk("short_locked", 64'(locked), 0);
        chk("short_ovf", 64'(overflow), 0);
        chk("short_busy", 64'(busy), 0);
`ifdef HDMI_CAPTURE_STATS_EN
        chk("stats_frames", 64'(frames), 6);
        chk("stats_drops", 64'(drops), 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
